// File: rtl/piece_queue_if.sv
// ---------------------------------------------------------------------------
// piece_queue_if
//   Bundles the piece queue's data-path signals so the game FSM, the preview
//   renderer and the queue itself share one connection.
//
//   Signals
//     random_in   [2:0]         randomizer code sampled by the queue (1..7 legal)
//     pop                       consume the head piece
//     piece_out   [2:0]         head piece ID, 0 when empty
//     piece_valid               head entry holds a piece
//     preview     [3*DEPTH-1:0] entry i at [3i+2:3i], i=0 is the head
//     count       [2:0]         number of valid entries
//     full                      count == DEPTH
//
//   Modports
//     master : game side, drives random_in/pop and observes the queue
//     slave  : the queue itself
// ---------------------------------------------------------------------------
interface piece_queue_if #(
    parameter int DEPTH = 3
) ();
    logic [2:0]         random_in;
    logic               pop;
    logic [2:0]         piece_out;
    logic               piece_valid;
    logic [3*DEPTH-1:0] preview;
    logic [2:0]         count;
    logic               full;

    modport master (
        output random_in, pop,
        input  piece_out, piece_valid, preview, count, full
    );

    modport slave (
        input  random_in, pop,
        output piece_out, piece_valid, preview, count, full
    );
endinterface

// File: rtl/piece_queue.sv
// ---------------------------------------------------------------------------
// piece_queue
//   Turns the free-running 1..7 randomizer into an ordered queue of upcoming
//   tetromino IDs. Samples are spaced at least FILL_GAP cycles apart and a
//   sample is rejected if it is an invalid code or repeats the last accepted
//   piece, so the sequence does not simply track the randomizer's cycle.
//
//   Parameters
//     DEPTH     queue entries including the head (2..6)
//     FILL_GAP  minimum cycles between accepted samples (not a multiple of 7)
//
//   Ports
//     clk  system clock
//     rst  synchronous active-high reset
//     q    piece_queue_if.slave (random_in, pop in; piece_out, piece_valid,
//          preview, count, full out; all outputs registered)
//
//   Build option
//     PIECE_QUEUE_BAG7_EN  when defined, 7-bag mode: a used-piece mask replaces
//                          the repeat-of-last rule, so every bag of 7 accepted
//                          pieces is a permutation of 1..7.
// ---------------------------------------------------------------------------
module piece_queue #(
    parameter int DEPTH    = 3,
    parameter int FILL_GAP = 13
) (
    input  logic          clk,
    input  logic          rst,
    piece_queue_if.slave  q
);
    typedef enum logic {
        FILL,
        READY
    } state_t;

    localparam int             GW         = (FILL_GAP > 2) ? $clog2(FILL_GAP) : 1;
    localparam logic [GW-1:0]  GAP_RELOAD = GW'(FILL_GAP - 1);
    localparam logic [2:0]     DEPTH_C    = 3'(DEPTH);

    state_t        state_q, state_d;
    logic [2:0]    slot_q [DEPTH];
    logic [2:0]    slot_d [DEPTH];
    logic [2:0]    count_q, count_d;
    logic          valid_q, full_q;
    logic [GW-1:0] gap_q, gap_d;
    logic [2:0]    wr_idx;
    logic          pop_ok, eligible, code_ok, fresh, accept;

`ifdef PIECE_QUEUE_BAG7_EN
    logic [6:0] used_q, used_d, used_set;
    logic [7:0] used_ext;
`else
    logic [2:0] last_q, last_d;
`endif

    // A sample is taken whenever there is room (FILL) or room is being made
    // by a pop; either way only once the spacing counter has run out.
    assign pop_ok   = q.pop && valid_q;
    assign eligible = (gap_q == '0) && ((state_q == FILL) || pop_ok);
    assign code_ok  = (q.random_in != 3'd0);

`ifdef PIECE_QUEUE_BAG7_EN
    // Bit 0 is a dummy for code 0 so the code indexes the mask directly.
    assign used_ext = {used_q, 1'b0};
    assign fresh    = !used_ext[q.random_in];
`else
    assign fresh    = (q.random_in != last_q);
`endif

    assign accept = eligible && code_ok && fresh;

    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        slot_d  = slot_q;
        count_d = count_q;
        gap_d   = gap_q;
        state_d = state_q;
        wr_idx  = pop_ok ? (count_q - 3'd1) : count_q;

        if (pop_ok) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                slot_d[i] = slot_q[i + 1];
            end
            slot_d[DEPTH-1] = '0;
        end

        // The write index already accounts for the shift, so a pop and an
        // accept in the same cycle leave the new piece at the new tail.
        if (accept) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (3'(i) == wr_idx) slot_d[i] = q.random_in;
            end
        end

        if (accept && !pop_ok)      count_d = count_q + 3'd1;
        else if (!accept && pop_ok) count_d = count_q - 3'd1;

        if (accept)              gap_d = GAP_RELOAD;
        else if (gap_q != '0)    gap_d = gap_q - GW'(1);

        unique case (state_q)
            FILL:    if (accept && count_d == DEPTH_C) state_d = READY;
            READY:   if (pop_ok && !accept)            state_d = FILL;
            default: state_d = FILL;
        endcase
    end

`ifdef PIECE_QUEUE_BAG7_EN
    // Completing a bag clears the mask in the same cycle the last piece of
    // the bag is accepted, so the next accept starts a fresh bag.
    always_comb begin
        used_set = used_q | (7'd1 << (q.random_in - 3'd1));
        used_d   = used_q;
        if (accept) used_d = (used_set == 7'h7F) ? 7'h00 : used_set;
    end
`else
    always_comb begin
        last_d = last_q;
        if (accept) last_d = q.random_in;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            count_q <= '0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
            gap_q   <= '0;
            // NOTE: the slot array is reset, not just invalidated by count,
            // because empty slots must read 0 on the preview outputs.
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
`ifdef PIECE_QUEUE_BAG7_EN
            used_q  <= '0;
`else
            last_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            valid_q <= (count_d != 3'd0);
            full_q  <= (count_d == DEPTH_C);
            gap_q   <= gap_d;
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
`ifdef PIECE_QUEUE_BAG7_EN
            used_q  <= used_d;
`else
            last_q  <= last_d;
`endif
        end
    end

    assign q.piece_out   = slot_q[0];
    assign q.piece_valid = valid_q;
    assign q.count       = count_q;
    assign q.full        = full_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_preview
        assign q.preview[3*g +: 3] = slot_q[g];
    end
endmodule

// File: tb/tb_piece_queue.sv
// ---------------------------------------------------------------------------
// tb_piece_queue
//   Self-checking bench for piece_queue (DEPTH=3, FILL_GAP=13): a table of
//   directed vectors, hand-written pop/accept corner sequences, a randomized
//   run against a queue-based reference model, and (with
//   PIECE_QUEUE_BAG7_EN) a bag-permutation check.
// ---------------------------------------------------------------------------
module tb_piece_queue;
    localparam int D  = 3;
    localparam int FG = 13;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    piece_queue_if #(.DEPTH(D)) q_if ();

    piece_queue #(.DEPTH(D), .FILL_GAP(FG)) dut (
        .clk (clk),
        .rst (rst),
        .q   (q_if.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: a plain FIFO of piece IDs ----------
    int       mq[$];
    int       m_last;
    int       m_gap;
    bit [6:0] m_used;

    task automatic m_step(input bit r_rst, input int r, input bit p);
        bit pop_ok, elig, acc, fresh;
        if (r_rst) begin
            mq.delete();
            m_last = 0;
            m_gap  = 0;
            m_used = '0;
            return;
        end
        pop_ok = p && (mq.size() > 0);
        elig   = (m_gap == 0) && ((mq.size() < D) || pop_ok);
`ifdef PIECE_QUEUE_BAG7_EN
        fresh  = (r >= 1 && r <= 7) ? !m_used[r-1] : 1'b0;
`else
        fresh  = (r != m_last);
`endif
        acc = elig && (r >= 1 && r <= 7) && fresh;
        if (pop_ok) void'(mq.pop_front());
        if (acc)    mq.push_back(r);
        if (acc)            m_gap = FG - 1;
        else if (m_gap > 0) m_gap = m_gap - 1;
        if (acc) begin
            m_last = r;
            m_used[r-1] = 1'b1;
            if (m_used == 7'h7F) m_used = '0;
        end
    endtask

    function automatic int m_preview();
        int v = 0;
        for (int i = 0; i < mq.size(); i++) v |= mq[i] << (3 * i);
        return v;
    endfunction

    // Apply one cycle of inputs, advance the model, sample 1 time unit later.
    task automatic drive(input bit r_rst, input int r, input bit p);
        rst          = r_rst;
        q_if.random_in = 3'(r);
        q_if.pop     = p;
        @(posedge clk);
        m_step(r_rst, r, p);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".count"},   32'(q_if.count),       32'(mq.size()));
        check({tag, ".head"},    32'(q_if.piece_out),   (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
        check({tag, ".valid"},   32'(q_if.piece_valid), 32'(mq.size() > 0));
        check({tag, ".full"},    32'(q_if.full),        32'(mq.size() == D));
        check({tag, ".preview"}, 32'(q_if.preview),     32'(m_preview()));
    endtask

    task automatic check_const(input string tag, input int c, input int h,
                               input bit v, input bit f, input int pv);
        check({tag, ".count"},   32'(q_if.count),       32'(c));
        check({tag, ".head"},    32'(q_if.piece_out),   32'(h));
        check({tag, ".valid"},   32'(q_if.piece_valid), 32'(v));
        check({tag, ".full"},    32'(q_if.full),        32'(f));
        check({tag, ".preview"}, 32'(q_if.preview),     32'(pv));
    endtask

    // ---------------- directed vector table ------------------------------
    typedef struct {
        int ncyc;     // cycles to hold these inputs
        bit rst;
        bit cyc;      // random_in follows the 1..7 cycle counted from reset
        int rin;      // fixed random_in when cyc=0
        bit pop;
        int e_count;
        int e_head;
        bit e_valid;
        bit e_full;
        int e_prev;
    } vec_t;

    vec_t vt[$];

    initial begin
        int cyc_idx;
        int got[$];
        int phase_pop;
        bit done;

        rst = 1'b1;
        q_if.random_in = '0;
        q_if.pop = 1'b0;

        // Cycling 1..7: accepts at edges 1, 14, 27 pick 1, 7, 6.
        vt.push_back('{2,  1, 0, 0, 0, 0, 0, 0, 0, 0});
        vt.push_back('{1,  0, 1, 0, 0, 1, 1, 1, 0, 1});
        vt.push_back('{12, 0, 1, 0, 0, 1, 1, 1, 0, 1});
        vt.push_back('{1,  0, 1, 0, 0, 2, 1, 1, 0, 57});
        vt.push_back('{12, 0, 1, 0, 0, 2, 1, 1, 0, 57});
        vt.push_back('{1,  0, 1, 0, 0, 3, 1, 1, 1, 441});
        vt.push_back('{20, 0, 1, 0, 0, 3, 1, 1, 1, 441});
        // Reset with pop asserted, then constant 4: one accept only.
        vt.push_back('{1,  1, 0, 4, 1, 0, 0, 0, 0, 0});
        vt.push_back('{1,  0, 0, 4, 0, 1, 4, 1, 0, 4});
        vt.push_back('{40, 0, 0, 4, 0, 1, 4, 1, 0, 4});
        // Pop the 4 with invalid code held, then pop while empty.
        vt.push_back('{1,  0, 0, 0, 1, 0, 0, 0, 0, 0});
        vt.push_back('{3,  0, 0, 0, 1, 0, 0, 0, 0, 0});

        cyc_idx = 0;
        foreach (vt[k]) begin
            for (int n = 0; n < vt[k].ncyc; n++) begin
                if (vt[k].rst) begin
                    cyc_idx = 0;
                    drive(1'b1, vt[k].rin, vt[k].pop);
                end else begin
                    drive(1'b0, vt[k].cyc ? (cyc_idx % 7) + 1 : vt[k].rin, vt[k].pop);
                    cyc_idx++;
                end
            end
            check_const($sformatf("vec%0d", k), vt[k].e_count, vt[k].e_head,
                        vt[k].e_valid, vt[k].e_full, vt[k].e_prev);
        end

        // Full {2,5,3}, pop once, duplicate rejected, then refill with 4.
        drive(1'b1, 0, 0);
        drive(1'b0, 2, 0);
        repeat (12) drive(1'b0, 0, 0);
        drive(1'b0, 5, 0);
        repeat (12) drive(1'b0, 0, 0);
        drive(1'b0, 3, 0);
        check_const("full253", 3, 2, 1, 1, 234);
        drive(1'b0, 0, 1);
        check_const("pop253", 2, 5, 1, 0, 29);
        repeat (15) drive(1'b0, 3, 0);
        check_const("dup_rej", 2, 5, 1, 0, 29);
        drive(1'b0, 4, 0);
        check_const("refill4", 3, 5, 1, 1, 285);

        // Pop coincident with accept of 6 on {1,2}.
        drive(1'b1, 0, 0);
        drive(1'b0, 1, 0);
        repeat (12) drive(1'b0, 0, 0);
        drive(1'b0, 2, 0);
        repeat (12) drive(1'b0, 0, 0);
        drive(1'b0, 6, 1);
        check_const("pop_acc", 2, 2, 1, 0, 50);

        // Reset mid-fill (count=2) with pop and a valid code present.
        drive(1'b1, 5, 1);
        check_const("mid_rst", 0, 0, 0, 0, 0);

        // Randomized run against the model, pop rate varied by phase.
        for (int ph = 0; ph < 8; ph++) begin
            phase_pop = (ph % 4 == 0) ? 0 : (ph % 4 == 1) ? 15 : (ph % 4 == 2) ? 4 : 2;
            for (int n = 0; n < 500; n++) begin
                drive($urandom_range(0, 599) == 0,
                      (ph >= 4) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 7)),
                      (phase_pop != 0) && ($urandom_range(0, phase_pop - 1) == 0));
                check_model($sformatf("rnd%0d", ph));
            end
        end

`ifdef PIECE_QUEUE_BAG7_EN
        // Pop every piece as soon as it appears; the popped order is the
        // accepted order, so each group of 7 must cover 1..7 exactly.
        drive(1'b1, 0, 0);
        done = 1'b0;
        for (int n = 0; n < 4000 && !done; n++) begin
            if (q_if.piece_valid) got.push_back(int'(q_if.piece_out));
            drive(1'b0, $urandom_range(0, 7), q_if.piece_valid);
            if (got.size() >= 14) done = 1'b1;
        end
        check("bag_collect", 32'(done), 32'd1);
        for (int g = 0; g < 2; g++) begin
            bit [7:0] seen = '0;
            for (int j = 0; j < 7; j++)
                if (got.size() > 7 * g + j) seen[got[7*g+j]] = 1'b1;
            check($sformatf("bag%0d_perm", g), 32'(seen), 32'h0FE);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
